// File: rtl/freq_edge_gate_if.sv
// Signal bundle between the ADC front end / result consumer and the frequency gate.
// The master side drives the ADC samples and reads the results; the slave side is the gate itself.
interface freq_edge_gate_if;
    logic        ad_clk;
    logic [7:0]  ad_data;
    logic [23:0] freq;
    logic        freq_valid;
    logic        no_signal;

    modport master (
        output ad_data,
        input  ad_clk,
        input  freq,
        input  freq_valid,
        input  no_signal
    );

    modport slave (
        input  ad_data,
        output ad_clk,
        output freq,
        output freq_valid,
        output no_signal
    );
endinterface

// File: rtl/freq_edge_gate.sv
// Frequency counter for an ADC-sampled waveform.
// The samples go through a hysteresis comparator and an edge detector.
// Rising edges are counted over fixed gate windows of CLK_FREQ cycles.
// The count of each completed window is published with a one-cycle valid pulse.
// The very first window after reset is discarded because the comparator starts in an unknown relation to the input.
module freq_edge_gate #(
    parameter int         CLK_FREQ = 27_000_000,
    parameter logic [7:0] TH_HI    = 8'd160,
    parameter logic [7:0] TH_LO    = 8'd96
) (
    input logic             clk,
    input logic             rstn,
    freq_edge_gate_if.slave bus
);

    typedef enum logic {
        WARMUP,
        RUN
    } state_t;

    localparam logic [23:0] TC_VALUE  = 24'(CLK_FREQ - 1);
    localparam logic [23:0] ECNT_MAX  = 24'hFFFFFF;

    logic [7:0]  sample_r;
    logic        sq;
    logic        sq_d;
    logic        rise;
    logic [23:0] gcnt;
    logic        tc;
    logic [23:0] ecnt;
    logic [23:0] closing_count;
    logic        publish;
    state_t      state;
    state_t      state_next;

    // The ADC runs from the system clock directly, so it keeps toggling through reset.
    assign bus.ad_clk = clk;

    // Register the ADC sample, then square it up with a hysteresis comparator and delay it for edge detection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sample_r <= 8'd0;
            sq       <= 1'b0;
            sq_d     <= 1'b0;
        end else begin
            sample_r <= bus.ad_data;
            if (sample_r >= TH_HI) begin
                sq <= 1'b1;
            end else if (sample_r <= TH_LO) begin
                sq <= 1'b0;
            end
            sq_d <= sq;
        end
    end

    assign rise = sq & ~sq_d;
    assign tc   = (gcnt == TC_VALUE);

    // Free-running gate counter; consecutive windows abut with no dead cycles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gcnt <= 24'd0;
        end else if (tc) begin
            gcnt <= 24'd0;
        end else begin
            gcnt <= gcnt + 24'd1;
        end
    end

    // Edge counter; a rise in the terminal cycle is folded into closing_count, so the new window starts at zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ecnt <= 24'd0;
        end else if (tc) begin
            ecnt <= 24'd0;
        end else if (rise && (ecnt != ECNT_MAX)) begin
            ecnt <= ecnt + 24'd1;
        end
    end

    // Window total including a possible rise in the terminal cycle, clamped at full scale.
    always_comb begin
        closing_count = ecnt;
        if (rise && (ecnt != ECNT_MAX)) begin
            closing_count = ecnt + 24'd1;
        end
    end

    // State register for the warm-up / run sequencing.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= WARMUP;
        end else begin
            state <= state_next;
        end
    end

    // Leave warm-up at the end of the first window; stay in run afterwards.
    always_comb begin
        state_next = state;
        if ((state == WARMUP) && tc) begin
            state_next = RUN;
        end
    end

    // Only windows closed while running are published.
    always_comb begin
        publish = 1'b0;
        if ((state == RUN) && tc) begin
            publish = 1'b1;
        end
    end

    // Result registers: freq and no_signal hold between publications, freq_valid pulses for one cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.freq       <= 24'd0;
            bus.freq_valid <= 1'b0;
            bus.no_signal  <= 1'b0;
        end else begin
            bus.freq_valid <= publish;
            if (publish) begin
                bus.freq      <= closing_count;
                bus.no_signal <= (closing_count == 24'd0);
            end
        end
    end

endmodule

// File: tb/tb_freq_edge_gate.sv
// Randomised scoreboard bench for freq_edge_gate.
// Each segment builds an ADC sample sequence.
// From those samples, the expected count of every published window is computed from the threshold rules.
// The expected results are queued before the segment is played.
// A negedge monitor pops the queue and compares whenever freq_valid is seen, and also checks pulse timing.
module tb_freq_edge_gate;

    localparam int         CF     = 1000;
    localparam logic [7:0] TB_HI  = 8'd160;
    localparam logic [7:0] TB_LO  = 8'd96;

    typedef struct {
        logic [23:0] freq;
        logic        no_signal;
    } result_t;

    logic clk;
    logic rstn;
    freq_edge_gate_if bus();

    result_t exp_q[$];
    int      x[];
    int      edge_cnt;
    int      last_valid_edge;
    bit      prev_fv;
    int      checks;
    int      errors;

    freq_edge_gate #(
        .CLK_FREQ(CF),
        .TH_HI   (TB_HI),
        .TH_LO   (TB_LO)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    // 10 ns system clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_val(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference model: threshold rules applied sample by sample.
    // A rise is seen in the cycle that starts two edges after the sample is taken.
    // That cycle belongs to window (edge index)/CF.
    task automatic push_expected(input int last_edge);
        int      nwin;
        int      cnt[];
        bit      level;
        bit      nl;
        int      w;
        result_t r;
        nwin  = last_edge / CF;
        cnt   = new[nwin + 1];
        foreach (cnt[i]) cnt[i] = 0;
        level = 1'b0;
        for (int n = 1; n < x.size(); n++) begin
            if (x[n] >= int'(TB_HI)) nl = 1'b1;
            else if (x[n] <= int'(TB_LO)) nl = 1'b0;
            else nl = level;
            if (nl && !level) begin
                w = (n + 1) / CF;
                if (w <= nwin && cnt[w] < 24'hFFFFFF) cnt[w]++;
            end
            level = nl;
        end
        for (int i = 1; i < nwin; i++) begin
            r.freq      = 24'(cnt[i]);
            r.no_signal = (cnt[i] == 0);
            exp_q.push_back(r);
        end
    endtask

    // Fill x[1..n] with the sample sequence of the requested kind.
    task automatic applyStimulus(input int kind, input int n_edges);
        int c;
        int run_left;
        int held;
        x = new[n_edges + 1];
        x[0] = 0;
        c = int'($urandom_range(0, 255));
        run_left = 0;
        held = 0;
        for (int n = 1; n <= n_edges; n++) begin
            case (kind)
                0: x[n] = ((n / 10) % 2 == 1) ? 255 : 0;
                1: x[n] = (n <= 50) ? 0 : ((n % 2 == 1) ? 136 : 120);
                2: x[n] = (n % 2 == 1) ? 255 : 0;
                3: x[n] = int'($urandom_range(0, 255));
                4: x[n] = c;
                5: x[n] = (n >= 2 * CF - 2) ? 255 : 0;
                default: begin
                    if (run_left == 0) begin
                        held     = int'($urandom_range(0, 255));
                        run_left = int'($urandom_range(1, 15));
                    end
                    x[n] = held;
                    run_left--;
                end
            endcase
        end
    endtask

    // One segment: reset, queue expected results, release, then play the samples edge by edge.
    task automatic checkOutput(input string name, input int kind, input int n_edges, input bit mid_reset);
        @(negedge clk);
        rstn = 1'b0;
        bus.ad_data = 8'd0;
        repeat (2) begin
            @(negedge clk);
            #1;
            check_val({name, "_adclk_low_in_reset"}, bus.ad_clk, 0);
            @(posedge clk);
            #1;
            check_val({name, "_adclk_high_in_reset"}, bus.ad_clk, 1);
        end
        check_val({name, "_reset_freq"}, bus.freq, 0);
        check_val({name, "_reset_valid"}, bus.freq_valid, 0);
        check_val({name, "_reset_no_signal"}, bus.no_signal, 0);

        applyStimulus(kind, n_edges);
        push_expected(n_edges);

        @(negedge clk);
        edge_cnt = 0;
        rstn = 1'b1;
        for (int n = 1; n <= n_edges; n++) begin
            bus.ad_data = 8'(x[n]);
            @(posedge clk);
            edge_cnt = n;
            if (mid_reset && n == n_edges) begin
                #3;
                rstn = 1'b0;
                #1;
                check_val({name, "_async_reset_freq"}, bus.freq, 0);
                check_val({name, "_async_reset_valid"}, bus.freq_valid, 0);
                check_val({name, "_async_reset_no_signal"}, bus.no_signal, 0);
            end else begin
                @(negedge clk);
            end
        end
        #1;
        check_val({name, "_pending_results"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Monitor: compare each published result against the scoreboard and check pulse spacing.
    always @(negedge clk) begin
        result_t e;
        if (!rstn) begin
            last_valid_edge = 0;
            prev_fv = 1'b0;
        end else begin
            if (bus.freq_valid) begin
                check_val("valid_not_back_to_back", prev_fv, 0);
                if (exp_q.size() == 0) begin
                    check_val("unexpected_valid_freq", bus.freq, -1);
                end else begin
                    e = exp_q.pop_front();
                    check_val("freq", bus.freq, e.freq);
                    check_val("no_signal", bus.no_signal, e.no_signal);
                end
                if (last_valid_edge == 0) begin
                    check_val("first_valid_cycle", edge_cnt + 1, 2 * CF + 1);
                end else begin
                    check_val("valid_spacing", edge_cnt - last_valid_edge, CF);
                end
                last_valid_edge = edge_cnt;
            end
            prev_fv = bus.freq_valid;
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        edge_cnt = 0;
        last_valid_edge = 0;
        prev_fv = 1'b0;
        rstn = 1'b0;
        bus.ad_data = 8'd0;

        checkOutput("square20",    0, 4000, 1'b0);
        checkOutput("noise",       1, 4000, 1'b0);
        checkOutput("fast",        2, 3000, 1'b0);
        checkOutput("random",      3, 4000, 1'b0);
        checkOutput("held",        4, 3000, 1'b0);
        checkOutput("terminal",    5, 3000, 1'b0);
        checkOutput("random_runs", 6, 4000, 1'b0);
        checkOutput("mid_reset",   0, 2500, 1'b1);
        checkOutput("after_reset", 0, 3000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
